alu_74382_slice_seq: RTL



---
 rtl/alu_74382_slice_seq.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/alu_74382_slice_seq.sv
// Word-level sequencer around one alu_74382 slice.
// Streams a WORD_W operation through the slice one nibble per cycle, LSB first,
// rippling the slice carry, then presents the reassembled word result.
module alu_74382_slice_seq #(
  parameter  int unsigned WORD_W         = 16,
  localparam int unsigned ORIG_OPERAND_W = 4,
  parameter  int unsigned SLICE_W        = ORIG_OPERAND_W,
  localparam int unsigned SELECT_W       = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [SELECT_W-1:0] in_sel,
  input  logic                in_carry,
  input  logic [WORD_W-1:0]   in_a,
  input  logic [WORD_W-1:0]   in_b,
  output logic [SELECT_W-1:0] alu_sel,
  output logic                alu_carry_in,
  output logic [SLICE_W-1:0]  alu_a,
  output logic [SLICE_W-1:0]  alu_b,
  input  logic [SLICE_W-1:0]  alu_result,
  input  logic                alu_carry_out,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WORD_W-1:0]   out_result,
  output logic                out_carry,
  output logic                out_overflow
);

  localparam int unsigned NUM_SLICES = WORD_W / SLICE_W;
  localparam int unsigned K_W        = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;

  // alu_74382 function select encoding
  localparam logic [SELECT_W-1:0] OP_CLEAR   = 3'b000;
  localparam logic [SELECT_W-1:0] OP_B_SUB_A = 3'b001;
  localparam logic [SELECT_W-1:0] OP_A_SUB_B = 3'b010;
  localparam logic [SELECT_W-1:0] OP_ADD     = 3'b011;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e              state_q;
  state_e              state_d;
  logic [K_W-1:0]      k_q;
  logic                carry_q;
  logic [SELECT_W-1:0] sel_q;
  logic                cin_q;
  logic [WORD_W-1:0]   a_sh_q;
  logic [WORD_W-1:0]   b_sh_q;
  logic                a_msb_q;
  logic                b_msb_q;
  logic [WORD_W-1:0]   res_q;

  logic                accept_c;
  logic                last_c;
  logic                r_msb_c;
  logic                ovf_c;
  logic [WORD_W-1:0]   res_next_c;

  assign accept_c   = in_valid && in_ready;
  assign last_c     = (k_q == K_W'(NUM_SLICES - 1));
  assign r_msb_c    = alu_result[SLICE_W-1];
  // Newest nibble enters at the top; after the last slice the word is aligned
  assign res_next_c = (res_q >> SLICE_W) | (WORD_W'(alu_result) << (WORD_W - SLICE_W));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and slice-facing drive
  always_comb begin
    state_d      = state_q;
    in_ready     = 1'b0;
    alu_sel      = OP_CLEAR;
    alu_a        = '0;
    alu_b        = '0;
    alu_carry_in = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        alu_sel      = sel_q;
        alu_a        = a_sh_q[SLICE_W-1:0];
        alu_b        = b_sh_q[SLICE_W-1:0];
        alu_carry_in = (k_q == '0) ? cin_q : carry_q;
        if (last_c) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Word-level signed overflow from operand and final result MSBs
  always_comb begin
    ovf_c = 1'b0;
    unique case (sel_q)
      OP_ADD:     ovf_c = (a_msb_q == b_msb_q) && (r_msb_c != a_msb_q);
      OP_A_SUB_B: ovf_c = (a_msb_q != b_msb_q) && (r_msb_c != a_msb_q);
      OP_B_SUB_A: ovf_c = (a_msb_q != b_msb_q) && (r_msb_c != b_msb_q);
      default:    ovf_c = 1'b0;
    endcase
  end

  // Operand latch, nibble stepping and result capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_q          <= '0;
      carry_q      <= 1'b0;
      sel_q        <= '0;
      cin_q        <= 1'b0;
      a_sh_q       <= '0;
      b_sh_q       <= '0;
      a_msb_q      <= 1'b0;
      b_msb_q      <= 1'b0;
      res_q        <= '0;
      out_valid    <= 1'b0;
      out_result   <= '0;
      out_carry    <= 1'b0;
      out_overflow <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (accept_c) begin
            sel_q   <= in_sel;
            cin_q   <= in_carry;
            a_sh_q  <= in_a;
            b_sh_q  <= in_b;
            a_msb_q <= in_a[WORD_W-1];
            b_msb_q <= in_b[WORD_W-1];
            k_q     <= '0;
          end
        end
        S_RUN: begin
          k_q     <= k_q + K_W'(1);
          carry_q <= alu_carry_out;
          res_q   <= res_next_c;
          a_sh_q  <= a_sh_q >> SLICE_W;
          b_sh_q  <= b_sh_q >> SLICE_W;
          if (last_c) begin
            out_valid    <= 1'b1;
            out_result   <= res_next_c;
            out_carry    <= alu_carry_out;
            out_overflow <= ovf_c;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        default: begin
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
